video_pattern_source: RTL

- Transmitter for the team's dtype-tagged pixel stream: dvo/dtypeo/meta_datao plus r/g/b.
- Generates complete synthetic frames for bench and on-chip self-test of the downstream imager pipeline stages, such as crop, debayer and colour stages.
- Emits frame/row framing beats and pixel beats in the exact order those consumers expect, with programmable geometry, blanking and test pattern.

---
 rtl/video_pattern_source.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_source
// Brief    : Synthetic frame generator for the dtype-tagged pixel stream.
// Revision : 1.0
// ============================================================================

// Beat type codes; guarded so a project-wide dtypes definition takes precedence.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 5
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 5'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 5'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 5'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 5'h08
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 5'h10
`endif

module video_pattern_source #(
    parameter int PIXEL_WIDTH = 10,
    parameter int DIM_WIDTH   = 12
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic [DIM_WIDTH-1:0]    num_cols,
    input  logic [DIM_WIDTH-1:0]    num_rows,
    input  logic [DIM_WIDTH-1:0]    hblank,
    input  logic [DIM_WIDTH-1:0]    vblank,
    input  logic [1:0]              pattern,
    output logic                    dvo,
    output logic [PIXEL_WIDTH-1:0]  ro,
    output logic [PIXEL_WIDTH-1:0]  go,
    output logic [PIXEL_WIDTH-1:0]  bo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]             meta_datao,
    output logic                    busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FSTART, ST_RSTART, ST_PIXEL,
        ST_REND, ST_HBLANK, ST_FEND, ST_VBLANK
    } state_t;

    // r_state names the beat currently on the outputs; everything below
    // computes the next beat so that all outputs come straight from flops.
    state_t                  r_state, w_state;
    logic [DIM_WIDTH-1:0]    r_col, w_col;
    logic [DIM_WIDTH-1:0]    r_row, w_row;
    logic [DIM_WIDTH-1:0]    r_cnt, w_cnt;
    logic [DIM_WIDTH-1:0]    r_cols, r_rows, r_hblank, r_vblank;
    logic [1:0]              r_pattern;
    logic [15:0]             r_frame_cnt;
    logic                    w_start, w_latch;
    logic                    w_dvo;
    logic [`DTYPE_WIDTH-1:0] w_dtype;
    logic [15:0]             w_meta;
    logic [PIXEL_WIDTH-1:0]  w_r, w_g, w_b;
    logic [PIXEL_WIDTH-1:0]  w_pc, w_pr;

    assign w_start = enable && (num_cols != '0) && (num_rows != '0);

    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        w_cnt   = r_cnt;
        w_latch = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_latch = 1'b1;
                    w_state = ST_FSTART;
                end
            end
            ST_FSTART: w_state = ST_RSTART;
            ST_RSTART: begin
                w_state = ST_PIXEL;
                w_col   = '0;
            end
            ST_PIXEL: begin
                if (r_col == r_cols - DIM_WIDTH'(1)) w_state = ST_REND;
                else                                 w_col   = r_col + DIM_WIDTH'(1);
            end
            ST_REND: begin
                w_row = r_row + DIM_WIDTH'(1);
                if (r_hblank != '0) begin
                    w_state = ST_HBLANK;
                    w_cnt   = DIM_WIDTH'(1);
                end else if (w_row < r_rows) begin
                    w_state = ST_RSTART;
                end else begin
                    w_state = ST_FEND;
                end
            end
            ST_HBLANK: begin
                if (r_cnt == r_hblank) w_state = (r_row < r_rows) ? ST_RSTART : ST_FEND;
                else                   w_cnt   = r_cnt + DIM_WIDTH'(1);
            end
            ST_FEND: begin
                if (r_vblank != '0) begin
                    w_state = ST_VBLANK;
                    w_cnt   = DIM_WIDTH'(1);
                end else if (w_start) begin
                    w_latch = 1'b1;
                    w_state = ST_FSTART;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_VBLANK: begin
                if (r_cnt == r_vblank) begin
                    w_latch = w_start;
                    w_state = w_start ? ST_FSTART : ST_IDLE;
                end else begin
                    w_cnt = r_cnt + DIM_WIDTH'(1);
                end
            end
            default: w_state = ST_IDLE;
        endcase
        if (w_latch) w_row = '0;
    end

    // Pattern generation for the beat about to be registered.
    always_comb begin
        w_pc = PIXEL_WIDTH'(w_col);
        w_pr = PIXEL_WIDTH'(w_row);
        w_r  = '0;
        w_g  = '0;
        w_b  = '0;
        case (r_pattern)
            2'd0: begin w_r = w_pc; w_g = w_pc; w_b = w_pc; end
            2'd1: begin w_r = w_pr; w_g = w_pr; w_b = w_pr; end
            2'd2: begin
                w_r = (w_col[3] ^ w_row[3]) ? '1 : '0;
                w_g = w_r;
                w_b = w_r;
            end
            default: begin w_r = w_pc; w_g = w_pr; w_b = w_pc + w_pr; end
        endcase
    end

    always_comb begin
        w_dvo   = 1'b1;
        w_dtype = '0;
        w_meta  = '0;
        case (w_state)
            ST_FSTART: begin w_dtype = `DTYPE_FRAME_START; w_meta = r_frame_cnt;  end
            ST_RSTART: begin w_dtype = `DTYPE_ROW_START;   w_meta = 16'(w_row);   end
            ST_PIXEL:  begin w_dtype = `DTYPE_PIXEL_MASK;                         end
            ST_REND:   begin w_dtype = `DTYPE_ROW_END;     w_meta = 16'(w_row);   end
            ST_FEND:   begin w_dtype = `DTYPE_FRAME_END;   w_meta = 16'(r_rows);  end
            default:   w_dvo = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_cols      <= '0;
            r_rows      <= '0;
            r_hblank    <= '0;
            r_vblank    <= '0;
            r_pattern   <= '0;
            r_frame_cnt <= '0;
            dvo         <= 1'b0;
            dtypeo      <= '0;
            meta_datao  <= '0;
            ro          <= '0;
            go          <= '0;
            bo          <= '0;
            busy        <= 1'b0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;
            r_cnt   <= w_cnt;
            if (w_latch) begin
                r_cols    <= num_cols;
                r_rows    <= num_rows;
                r_hblank  <= hblank;
                r_vblank  <= vblank;
                r_pattern <= pattern;
            end
            // FRAME_END lasts one cycle, so this bumps the counter once per frame.
            if (w_state == ST_FEND) r_frame_cnt <= r_frame_cnt + 16'd1;
            dvo        <= w_dvo;
            dtypeo     <= w_dtype;
            meta_datao <= w_meta;
            ro         <= (w_state == ST_PIXEL) ? w_r : '0;
            go         <= (w_state == ST_PIXEL) ? w_g : '0;
            bo         <= (w_state == ST_PIXEL) ? w_b : '0;
            busy       <= (w_state != ST_IDLE);
        end
    end

endmodule

`default_nettype wire
